cf_share_compress: RTL and testbench

- Receiving end of the component-function layer of the low-latency masked SKINNY S-box.
- Captures the 2×9 expanded output shares produced by the component-function instances in a glitch-barrier register.
- Compresses each output bit back to 3 shares by XORing fixed groups of 3 expanded shares, then registers the result.
- Two-stage pipeline with valid/ready flow control. It sits between the component-function layer and the next S-box stage or the state register.

---
 rtl/cf_share_pkg.sv | 22 ++
 rtl/share_xor3.sv | 12 +
 rtl/cf_share_compress.sv | 77 +++++++
 tb/tb_cf_share_compress.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_share_pkg.sv
// Shared constants and share-index helpers for the component-function
// compression layer of the masked SKINNY S-box.
package cf_share_pkg;

  localparam int NUM_OUT    = 2;
  localparam int SHARES_OUT = 3;
  localparam int SHARES_IN  = SHARES_OUT * SHARES_OUT;

  localparam int IN_W  = NUM_OUT * SHARES_IN;
  localparam int OUT_W = NUM_OUT * SHARES_OUT;

  // Bit position of expanded share k of output bit j on the input bus.
  function automatic int in_idx(input int j, input int k);
    return j * SHARES_IN + k;
  endfunction

  // Bit position of compressed share g of output bit j on the output bus.
  function automatic int out_idx(input int j, input int g);
    return j * SHARES_OUT + g;
  endfunction

endpackage

// File: rtl/share_xor3.sv
// Single compression cell: XOR of three expanded shares. Kept as its own
// module so every compressed share remains a distinct, probeable cell.
module share_xor3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = a ^ b ^ c;

endmodule

// File: rtl/cf_share_compress.sv
// Receiving end of the component-function layer: registers the expanded
// shares behind a glitch barrier, then compresses each output bit from
// SHARES_IN back down to SHARES_OUT shares into a second register.
module cf_share_compress
  import cf_share_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_s
);

  logic              s1_valid;
  logic [IN_W-1:0]   s1_data;
  logic [OUT_W-1:0]  xor_s;
  logic              s2_free;
  logic              s1_adv;
  logic              accept;

  // Handshake decode; in_ready depends only on registered valids and out_ready.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    accept   = in_valid && in_ready;
  end

  // Compression cells read only the registered stage-1 shares, so the
  // fresh-mask terms never meet before the glitch barrier.
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_bit
    for (genvar g = 0; g < SHARES_OUT; g++) begin : g_share
      share_xor3 u_xor (
        .a (s1_data[in_idx(j, 3 * g)]),
        .b (s1_data[in_idx(j, 3 * g + 1)]),
        .c (s1_data[in_idx(j, 3 * g + 2)]),
        .y (xor_s[out_idx(j, g)])
      );
    end
  end

  // Stage 1 glitch barrier: capture in_q verbatim only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (accept) begin
        s1_data <= in_q;
      end
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: load compressed shares when stage 1 advances, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= '0;
    end else begin
      if (s1_adv) begin
        out_s     <= xor_s;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cf_share_compress.sv
// Self-checking bench for cf_share_compress: scoreboard of accepted inputs,
// directed latency/stream/stall/reset scenarios and a randomized run.
module tb_cf_share_compress;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_q;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_s;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;

  logic [17:0] sbQueue[$];
  int          outCycles[$];
  bit          streamMode = 0;
  bit          stallPrev  = 0;
  logic [5:0]  prevOut    = '0;
  bit          randDone   = 0;

  cf_share_compress dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to verify back-to-back output timing.
  always @(posedge clk) cycleCount++;

  // Reference compression: each output share is the XOR of three
  // consecutive expanded shares of its output bit.
  function automatic logic [5:0] compressModel(input logic [17:0] d);
    logic [5:0] r;
    r = '0;
    for (int j = 0; j < 2; j++)
      for (int g = 0; g < 3; g++)
        r[j*3+g] = d[j*9+3*g] ^ d[j*9+3*g+1] ^ d[j*9+3*g+2];
    return r;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               tag, observed, expected, cycleCount);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded wait).
  task automatic applyStimulus(input logic [17:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_q     = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor, sampled on the falling edge: pops and compares on
  // each output handshake, pushes on each input handshake, and checks that
  // a stalled output holds steady.
  always @(negedge clk) begin
    logic [17:0] d;
    if (!rst_n) begin
      sbQueue.delete();
      stallPrev = 0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_hold", out_s, prevOut);
      end
      if (streamMode) checkOutput("stream_ready", in_ready, 1);
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_out", 1, 0);
        end else begin
          d = sbQueue.pop_front();
          checkOutput("out_s", out_s, compressModel(d));
          for (int j = 0; j < 2; j++)
            checkOutput("bit_parity", ^out_s[j*3 +: 3], ^d[j*9 +: 9]);
          if (streamMode) outCycles.push_back(cycleCount);
        end
      end
      if (in_valid && in_ready) sbQueue.push_back(in_q);
      stallPrev = out_valid && !out_ready;
      prevOut   = out_s;
    end
  end

  initial begin
    int n;
    rst_n     = 0;
    in_valid  = 0;
    in_q      = '0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_s", out_s, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;

    // Single beat: out_valid pulses exactly two cycles after presentation.
    applyStimulus(18'h00007);
    @(negedge clk);
    checkOutput("lat_early", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_data", out_s, 6'b000001);
    @(negedge clk);
    checkOutput("lat_clear", out_valid, 0);
    @(posedge clk);
    #1;

    // All-ones and a single full group.
    applyStimulus(18'h3FFFF);
    applyStimulus(18'h001FF);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back stream of four beats, expecting 1,1,1,2 consecutively.
    streamMode = 1;
    outCycles.delete();
    applyStimulus(18'h1);
    applyStimulus(18'h2);
    applyStimulus(18'h4);
    applyStimulus(18'h8);
    repeat (4) @(posedge clk);
    #1;
    streamMode = 0;
    checkOutput("stream_count", outCycles.size(), 4);
    if (outCycles.size() == 4)
      for (int i = 1; i < 4; i++)
        checkOutput("stream_gap", outCycles[i] - outCycles[i-1], 1);

    // Stall: two beats fill the pipe, the third waits for release.
    out_ready = 0;
    applyStimulus(18'h00015);
    applyStimulus(18'h2A000);
    in_valid = 1;
    in_q     = 18'h12345;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1;

    // Reset with both stages full discards everything.
    out_ready = 0;
    applyStimulus(18'h0ABCD);
    applyStimulus(18'h3F0F0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_s", out_s, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_out", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(18'($urandom));
        end
        randDone = 1;
      end
      begin
        while (!randDone) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1;
    n = 0;
    while ((sbQueue.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("drain_empty", sbQueue.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
